// File: rtl/vga_capture_rx.sv
// vga_capture_rx: samples VGA pins in the pixel clock domain and
// streams active pixels as RGB565 beats with recovered coordinates.
module vga_capture_rx #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter bit SYNC_POL   = 1'b0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        csi_vga_clock_clk,
  input  logic        rsi_vga_reset_reset,
  input  logic        coe_locked_export,
  input  logic [7:0]  coe_vga_red,
  input  logic [7:0]  coe_vga_green,
  input  logic [7:0]  coe_vga_blue,
  input  logic        coe_vga_blank_n,
  input  logic        coe_vga_hsync,
  input  logic        coe_vga_vsync,
  output logic [15:0] aso_pix_data,
  output logic [9:0]  aso_pix_x,
  output logic [9:0]  aso_pix_y,
  output logic        aso_pix_sof,
  output logic        aso_pix_eol,
  output logic        aso_pix_valid,
  input  logic        aso_pix_ready,
  input  logic        avs_stat_clear,
  output logic [15:0] avs_stat_frames,
  output logic        avs_stat_err_ovf,
  output logic        avs_stat_err_geom
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = 38;
  localparam logic [10:0] H11 = 11'(H_ACTIVE);
  localparam logic [10:0] V11 = 11'(V_ACTIVE);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    SEEK, VBLANK, ACTIVE, HBLANK
  } state_t;

  logic clk;
  logic rst;
  assign clk = csi_vga_clock_clk;
  assign rst = rsi_vga_reset_reset | ~coe_locked_export;

  logic [4:0] r_q;
  logic [5:0] g_q;
  logic [4:0] b_q;
  logic       blank_q;
  logic       hs_q;
  logic       vs_q;
  logic       vs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      blank_q <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      vs_d    <= ~SYNC_POL;
    end else begin
      r_q     <= coe_vga_red[7:3];
      g_q     <= coe_vga_green[7:2];
      b_q     <= coe_vga_blue[7:3];
      blank_q <= coe_vga_blank_n;
      hs_q    <= coe_vga_hsync;
      vs_q    <= coe_vga_vsync;
      vs_d    <= vs_q;
    end
  end

  // Line boundaries come from blank_n; hsync is sampled but not needed.
  logic unused_bits;
  assign unused_bits = &{1'b0, coe_vga_red[2:0],
                         coe_vga_green[1:0],
                         coe_vga_blue[2:0], hs_q};

  logic vs_lead;
  assign vs_lead = (vs_q == SYNC_POL) && (vs_d != SYNC_POL);

  state_t      state, state_nx;
  logic [9:0]  x, x_nx, y, y_nx;
  logic [9:0]  x_inc, y_inc;
  logic [9:0]  cx, cy;
  logic [10:0] lines;
  logic        cap, in_rng, geom_set, frame_end;

  assign x_inc = (x == 10'h3FF) ? x : x + 10'd1;
  assign y_inc = (y == 10'h3FF) ? y : y + 10'd1;
  assign lines = {1'b0, y} + 11'd1;

  always_comb begin
    state_nx  = state;
    x_nx      = x;
    y_nx      = y;
    cx        = x;
    cy        = y;
    cap       = 1'b0;
    geom_set  = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      SEEK: begin
        if (vs_lead) state_nx = VBLANK;
      end
      VBLANK: begin
        x_nx = '0;
        y_nx = '0;
        cx   = '0;
        cy   = '0;
        if (blank_q) begin
          state_nx = ACTIVE;
          cap      = 1'b1;
          x_nx     = 10'd1;
        end
      end
      ACTIVE: begin
        if (vs_lead) begin
          state_nx  = VBLANK;
          frame_end = 1'b1;
        end else if (blank_q) begin
          cap  = 1'b1;
          x_nx = x_inc;
        end else begin
          state_nx = HBLANK;
          geom_set = ({1'b0, x} != H11);
        end
      end
      HBLANK: begin
        if (vs_lead) begin
          state_nx  = VBLANK;
          frame_end = 1'b1;
        end else if (blank_q) begin
          state_nx = ACTIVE;
          cap      = 1'b1;
          cx       = '0;
          cy       = y_inc;
          x_nx     = 10'd1;
          y_nx     = y_inc;
        end
      end
      default: state_nx = SEEK;
    endcase
    in_rng = ({1'b0, cx} < H11) && ({1'b0, cy} < V11);
    if (cap && !in_rng) geom_set = 1'b1;
    if (frame_end && (lines != V11)) geom_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEEK;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_nx;
      x     <= x_nx;
      y     <= y_nx;
    end
  end

  logic          wr_v;
  logic [WW-1:0] wr_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_v    <= 1'b0;
      wr_word <= '0;
    end else begin
      wr_v    <= cap & in_rng;
      wr_word <= {r_q, g_q, b_q, cx, cy,
                  (cx == 10'd0) && (cy == 10'd0),
                  ({1'b0, cx} == H11 - 11'd1)};
    end
  end

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          full, empty, push, pop;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign pop   = ~empty & aso_pix_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign push  = wr_v & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  logic [WW-1:0] rd_word;
  assign rd_word       = empty ? '0 : mem[rp];
  assign aso_pix_valid = ~empty;
  assign aso_pix_data  = rd_word[37:22];
  assign aso_pix_x     = rd_word[21:12];
  assign aso_pix_y     = rd_word[11:2];
  assign aso_pix_sof   = rd_word[1];
  assign aso_pix_eol   = rd_word[0];

  logic ovf_set;
  assign ovf_set = wr_v & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      avs_stat_frames   <= '0;
      avs_stat_err_ovf  <= 1'b0;
      avs_stat_err_geom <= 1'b0;
    end else begin
      avs_stat_frames   <= avs_stat_frames + 16'(frame_end);
      avs_stat_err_ovf  <= ovf_set |
                           (avs_stat_err_ovf & ~avs_stat_clear);
      avs_stat_err_geom <= geom_set |
                           (avs_stat_err_geom & ~avs_stat_clear);
    end
  end

endmodule

// File: tb/tb_vga_capture_rx.sv
// tb_vga_capture_rx: random video frames against a frame-level model,
// with a queue scoreboard checked by an independent beat monitor.
module tb_vga_capture_rx;

  localparam int H = 4;
  localparam int V = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        locked = 1'b1;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic        blank_n = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic        ready = 1'b0, clr = 1'b0;
  logic [15:0] data;
  logic [9:0]  px, py;
  logic        sof, eol, valid;
  logic [15:0] frames;
  logic        ovf, geom;

  vga_capture_rx #(
    .H_ACTIVE(H), .V_ACTIVE(V),
    .SYNC_POL(1'b0), .FIFO_DEPTH(D)
  ) dut (
    .csi_vga_clock_clk(clk),
    .rsi_vga_reset_reset(rst),
    .coe_locked_export(locked),
    .coe_vga_red(red),
    .coe_vga_green(green),
    .coe_vga_blue(blue),
    .coe_vga_blank_n(blank_n),
    .coe_vga_hsync(hsync),
    .coe_vga_vsync(vsync),
    .aso_pix_data(data),
    .aso_pix_x(px),
    .aso_pix_y(py),
    .aso_pix_sof(sof),
    .aso_pix_eol(eol),
    .aso_pix_valid(valid),
    .aso_pix_ready(ready),
    .avs_stat_clear(clr),
    .avs_stat_frames(frames),
    .avs_stat_err_ovf(ovf),
    .avs_stat_err_geom(geom)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  logic [37:0] exp_q[$];

  bit armed, in_frame, m_geom, m_ovf;
  bit rand_ready, white00;
  int m_lines, m_frames;
  int cap_left = -1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    if (rand_ready) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pix(input int j, input int li,
                     input logic [7:0] r, g, b);
    if (!armed) return;
    if (j < H && li < V) begin
      if (cap_left == 0) m_ovf = 1'b1;
      else begin
        if (cap_left > 0) cap_left--;
        exp_q.push_back({r[7:3], g[7:2], b[7:3],
                         10'(j), 10'(li),
                         (j == 0 && li == 0), (j == H - 1)});
      end
    end else m_geom = 1'b1;
  endtask

  task automatic line(input int len, input int gap, input bit clr_mid);
    int li;
    li = m_lines;
    if (armed) begin
      in_frame = 1'b1;
      m_lines++;
    end
    for (int j = 0; j < len; j++) begin
      blank_n = 1'b1;
      if (white00 && j == 0 && li == 0) begin
        red = 8'hF8; green = 8'hFC; blue = 8'hF8;
      end else begin
        red = 8'($urandom);
        green = 8'($urandom);
        blue = 8'($urandom);
      end
      pix(j, li, red, green, blue);
      step();
    end
    blank_n = 1'b0;
    red = '0; green = '0; blue = '0;
    if (armed && len != H) m_geom = 1'b1;
    for (int k = 0; k < gap; k++) begin
      hsync = !(k >= 1 && k < 3);
      clr = clr_mid && (k == 1);
      // clear lands with the end-of-line length check
      if (clr) begin
        m_ovf = 1'b0;
        m_geom = armed && (len != H);
      end
      step();
    end
    clr = 1'b0;
    hsync = 1'b1;
  endtask

  task automatic vs();
    blank_n = 1'b0;
    vsync = 1'b0;
    step();
    step();
    if (armed && in_frame) begin
      m_frames++;
      if (m_lines != V) m_geom = 1'b1;
    end
    armed = 1'b1;
    in_frame = 1'b0;
    m_lines = 0;
    vsync = 1'b1;
    repeat (4) step();
  endtask

  task automatic pulse_clear();
    repeat (4) step();
    clr = 1'b1;
    m_geom = 1'b0;
    m_ovf = 1'b0;
    step();
    clr = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      step();
      k++;
    end
    chk("drain.pending", exp_q.size(), 0);
    repeat (3) step();
  endtask

  task automatic chk_stats(input string tag);
    repeat (4) step();
    chk({tag, ".frames"}, frames, 16'(m_frames));
    chk({tag, ".geom"}, geom, m_geom);
    chk({tag, ".ovf"}, ovf, m_ovf);
  endtask

  task automatic do_reset(input bit use_lock, input int n);
    if (use_lock) locked = 1'b0;
    else rst = 1'b1;
    exp_q.delete();
    armed = 1'b0;
    in_frame = 1'b0;
    m_lines = 0;
    m_frames = 0;
    m_geom = 1'b0;
    m_ovf = 1'b0;
    cap_left = -1;
    repeat (n) step();
    rst = 1'b0;
    locked = 1'b1;
  endtask

  task automatic mid_frame_reset(input bit use_lock, input string tag);
    ready = 1'b1;
    vs();
    line(4, 6, 0);
    ready = 1'b0;
    in_frame = 1'b1;
    m_lines++;
    for (int j = 0; j < 4; j++) begin
      blank_n = 1'b1;
      red = 8'($urandom);
      green = 8'($urandom);
      blue = 8'($urandom);
      pix(j, 1, red, green, blue);
      step();
    end
    chk({tag, ".queued"}, valid, 1);
    do_reset(use_lock, 1);
    chk({tag, ".flushed"}, valid, 0);
    ready = 1'b1;
    line(2, 6, 0);
    line(4, 6, 0);
    vs();
    line(4, 6, 0);
    line(4, 6, 0);
    vs();
    drain();
    chk_stats(tag);
  endtask

  always @(negedge clk) begin
    logic [37:0] cur;
    cur = {data, px, py, sof, eol};
    if (valid) begin
      if (ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat: got %h expected no beat", cur);
        end else chk("beat", cur, exp_q.pop_front());
      end else if (exp_q.size() != 0) begin
        chk("held", cur, exp_q[0]);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst.valid", valid, 0);
    chk("rst.data", data, 0);
    chk("rst.x", px, 0);
    chk("rst.y", py, 0);
    chk("rst.sof", sof, 0);
    chk("rst.eol", eol, 0);
    chk("rst.frames", frames, 0);
    chk("rst.ovf", ovf, 0);
    chk("rst.geom", geom, 0);
    rst = 1'b0;
    step();
    chk("post_rst.valid", valid, 0);
    ready = 1'b1;
    line(4, 6, 0);
    line(4, 6, 0);
    chk_stats("seek");

    white00 = 1'b1;
    vs();
    line(4, 6, 0);
    line(4, 6, 0);
    white00 = 1'b0;
    vs();
    drain();
    chk_stats("frame");

    ready = 1'b0;
    cap_left = D;
    line(4, 6, 0);
    line(4, 6, 0);
    chk_stats("ovf_hold");
    b0 = beats;
    ready = 1'b1;
    drain();
    chk("ovf.beats", beats - b0, D);
    cap_left = -1;
    vs();
    chk_stats("ovf_end");

    line(3, 6, 0);
    drain();
    chk_stats("short");
    pulse_clear();
    chk_stats("clear");
    line(5, 6, 1);
    drain();
    chk_stats("clr_vs_set");
    vs();
    pulse_clear();
    chk_stats("clear2");

    mid_frame_reset(1'b0, "rst_mid");
    mid_frame_reset(1'b1, "lock_mid");

    for (int f = 0; f < 5; f++) begin
      int nl;
      vs();
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++)
        line($urandom_range(3, 5), $urandom_range(3, 8), 0);
    end
    vs();
    drain();
    chk_stats("rand");

    rand_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      vs();
      line(4, 5, 0);
      drain();
    end
    rand_ready = 1'b0;
    ready = 1'b1;
    vs();
    drain();
    chk_stats("bp");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
